ghost_collision_scheduler: RTL and testbench

GHOST_COLLISION_SCHEDULER -- requirements
Module: ghost_collision_scheduler

---
 rtl/ghost_collision_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_ghost_collision_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ghost_collision_scheduler.sv
// Ghost/Pac proximity scan: one shared squared-distance datapath walks the four
// ghosts per frame_tick. Optional crash invulnerability window: GHOST_CRASH_INVULN_EN.
module ghost_collision_scheduler #(
  parameter int unsigned RADIUS_SQ    = 1024,
  parameter int unsigned INVULN_SCANS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] PacX,
  input  logic [9:0] Ghost1X,
  input  logic [9:0] Ghost2X,
  input  logic [9:0] Ghost3X,
  input  logic [9:0] Ghost4X,
  input  logic [8:0] PacY,
  input  logic [8:0] Ghost1Y,
  input  logic [8:0] Ghost2Y,
  input  logic [8:0] Ghost3Y,
  input  logic [8:0] Ghost4Y,
  output logic       busy,
  output logic       done,
  output logic [3:0] hit_mask,
  output logic       crash,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

  localparam logic [20:0] RADIUS_LIM = 21'(RADIUS_SQ);

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  pac_x_q, pac_x_d;
  logic [8:0]  pac_y_q, pac_y_d;
  logic [9:0]  gx_q [4];
  logic [9:0]  gx_d [4];
  logic [8:0]  gy_q [4];
  logic [8:0]  gy_d [4];
  logic        s1_valid_q, s1_valid_d;
  logic [1:0]  s1_idx_q, s1_idx_d;
  logic [9:0]  s1_dx_q, s1_dx_d;
  logic [8:0]  s1_dy_q, s1_dy_d;
  logic [3:0]  acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  hit_mask_q, hit_mask_d;
  logic        crash_q, crash_d;
  logic        overrun_q, overrun_d;
  logic [20:0] sum_s;
  logic        hit_s;
  logic        accept_s;
`ifdef GHOST_CRASH_INVULN_EN
  localparam int CW = $clog2(INVULN_SCANS + 2);
  logic [CW-1:0] inv_q, inv_d;
`endif

  // Second pipeline stage: 21 bits hold 1023^2 + 511^2 without overflow.
  always_comb begin
    sum_s = 21'(s1_dx_q) * 21'(s1_dx_q) + 21'(s1_dy_q) * 21'(s1_dy_q);
    hit_s = (sum_s < RADIUS_LIM);
  end

  // Next-state for the scheduler, datapath stages and registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    s1_valid_d = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_dx_d    = s1_dx_q;
    s1_dy_d    = s1_dy_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hit_mask_d = hit_mask_q;
    crash_d    = crash_q;
    // The done cycle still reports busy, so a tick there is an overrun too.
    accept_s   = frame_tick && !busy_q;
    overrun_d  = overrun_q | (frame_tick & busy_q);
`ifdef GHOST_CRASH_INVULN_EN
    inv_d      = inv_q;
`endif

    if (s1_valid_q) begin
      acc_d[s1_idx_q] = hit_s;
    end else begin
      acc_d = acc_d;
    end

    if (accept_s) begin
      busy_d = 1'b1;
    end else if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ISSUE;
          idx_d   = 2'd0;
          acc_d   = 4'b0000;
          pac_x_d = PacX;
          pac_y_d = PacY;
          gx_d    = '{Ghost1X, Ghost2X, Ghost3X, Ghost4X};
          gy_d    = '{Ghost1Y, Ghost2Y, Ghost3Y, Ghost4Y};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        s1_valid_d = 1'b1;
        s1_idx_d   = idx_q;
        s1_dx_d    = abs_diff(pac_x_q, gx_q[idx_q]);
        s1_dy_d    = 9'(abs_diff({1'b0, pac_y_q}, {1'b0, gy_q[idx_q]}));
        if (idx_q == 2'd3) begin
          state_d = DRAIN;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DRAIN: begin
        if (idx_q == 2'd1) begin
          state_d = REPORT;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      REPORT: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        hit_mask_d = acc_q;
`ifdef GHOST_CRASH_INVULN_EN
        if (inv_q != '0) begin
          crash_d = 1'b0;
          inv_d   = inv_q - CW'(1);
        end else if (|acc_q) begin
          crash_d = 1'b1;
          inv_d   = CW'(INVULN_SCANS);
        end else begin
          crash_d = 1'b0;
        end
`else
        crash_d = |acc_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      pac_x_q    <= 10'd0;
      pac_y_q    <= 9'd0;
      gx_q       <= '{default: 10'd0};
      gy_q       <= '{default: 9'd0};
      s1_valid_q <= 1'b0;
      s1_idx_q   <= 2'd0;
      s1_dx_q    <= 10'd0;
      s1_dy_q    <= 9'd0;
      acc_q      <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_mask_q <= 4'b0000;
      crash_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef GHOST_CRASH_INVULN_EN
      inv_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_dx_q    <= s1_dx_d;
      s1_dy_q    <= s1_dy_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_mask_q <= hit_mask_d;
      crash_q    <= crash_d;
      overrun_q  <= overrun_d;
`ifdef GHOST_CRASH_INVULN_EN
      inv_q      <= inv_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hit_mask = hit_mask_q;
  assign crash    = crash_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ghost_collision_scheduler.sv
// Randomized bench for ghost_collision_scheduler against a distance-rule model.
module tb_ghost_collision_scheduler;

`ifdef GHOST_CRASH_INVULN_EN
  localparam int INV = 2;
`else
  localparam int INV = 60;
`endif
  localparam int RAD = 1024;

  logic       clk, rst, frame_tick;
  logic [9:0] PacX, Ghost1X, Ghost2X, Ghost3X, Ghost4X;
  logic [8:0] PacY, Ghost1Y, Ghost2Y, Ghost3Y, Ghost4Y;
  logic       busy, done, crash, overrun;
  logic [3:0] hit_mask;

  int n_checks = 0;
  int n_err    = 0;
  int px, py;
  int gx[4];
  int gy[4];
  int m_ov  = 0;
  int m_inv = 0;

  ghost_collision_scheduler #(.RADIUS_SQ(RAD), .INVULN_SCANS(INV)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .PacX(PacX), .Ghost1X(Ghost1X), .Ghost2X(Ghost2X), .Ghost3X(Ghost3X), .Ghost4X(Ghost4X),
    .PacY(PacY), .Ghost1Y(Ghost1Y), .Ghost2Y(Ghost2Y), .Ghost3Y(Ghost3Y), .Ghost4Y(Ghost4Y),
    .busy(busy), .done(done), .hit_mask(hit_mask), .crash(crash), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_inputs();
    PacX = 10'(px); PacY = 9'(py);
    Ghost1X = 10'(gx[0]); Ghost2X = 10'(gx[1]); Ghost3X = 10'(gx[2]); Ghost4X = 10'(gx[3]);
    Ghost1Y = 9'(gy[0]);  Ghost2Y = 9'(gy[1]);  Ghost3Y = 9'(gy[2]);  Ghost4Y = 9'(gy[3]);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_mask"}, 32'(hit_mask), 32'd0);
    check_eq({tag, "_crash"}, 32'(crash), 32'd0);
    check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  // One full scan; extra (1..7) re-pulses frame_tick in that busy cycle, 0 = none.
  task automatic do_scan(input string tag, input int extra);
    int mask, crash_e, dx, dy;
    mask = 0;
    for (int i = 0; i < 4; i++) begin
      dx = px - gx[i]; if (dx < 0) dx = -dx;
      dy = py - gy[i]; if (dy < 0) dy = -dy;
      if (dx * dx + dy * dy < RAD) mask |= (1 << i);
    end
`ifdef GHOST_CRASH_INVULN_EN
    if (m_inv > 0) begin
      crash_e = 0;
      m_inv--;
    end else begin
      crash_e = (mask != 0) ? 1 : 0;
      if (crash_e == 1) m_inv = INV;
    end
`else
    crash_e = (mask != 0) ? 1 : 0;
`endif
    apply_inputs();
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_done"}, 32'(done), (c == 8) ? 32'd1 : 32'd0);
      if (c == 8) begin
        check_eq({tag, "_mask"}, 32'(hit_mask), 32'(mask));
        check_eq({tag, "_crash"}, 32'(crash), 32'(crash_e));
      end
      // Scramble live inputs; the scan must use its snapshot. Ghost2 lands on Pac at T2.
      px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 511));
      for (int i = 0; i < 4; i++) begin
        gx[i] = int'($urandom_range(0, 1023)); gy[i] = int'($urandom_range(0, 511));
      end
      if (c == 2) begin
        gx[1] = px; gy[1] = py;
      end
      apply_inputs();
      frame_tick = (c == extra);
      if (c == extra) m_ov = 1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_end"}, 32'(done), 32'd0);
    check_eq({tag, "_ovr"}, 32'(overrun), 32'(m_ov));
  endtask

  task automatic set_far();
    gx = '{500, 700, 900, 300};
    gy = '{400, 50, 300, 500};
  endtask

  initial begin
    int extra;
    rst = 1'b1; frame_tick = 1'b0;
    px = 0; py = 0; set_far();
    apply_inputs();
    #1;
    check_idle_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single close ghost (sum 500).
    px = 100; py = 100; set_far(); gx[0] = 120; gy[0] = 110;
    do_scan("g1_hit", 0);

    // Exactly on the radius: no hit, including the Pac > Ghost direction.
    px = 100; py = 100; set_far(); gx[2] = 132; gy[2] = 100; gx[3] = 68; gy[3] = 100;
    do_scan("radius_eq", 0);
    px = 100; py = 100; set_far(); gx[2] = 132; gy[2] = 100; gx[3] = 69; gy[3] = 100;
    do_scan("radius_in", 0);

    // Re-tick at T3: overrun sticks, single done.
    px = 300; py = 200; set_far(); gx[1] = 300; gy[1] = 200;
    do_scan("ovr_t3", 3);
    px = 10; py = 10; set_far();
    do_scan("ovr_hold", 0);

    // Reset mid-scan at T4.
    px = 100; py = 100; set_far(); gx[0] = 100; gy[0] = 100;
    apply_inputs();
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    m_ov = 0; m_inv = 0;
    for (int c = 0; c < 10; c++) begin
      check_eq("midrst_nodone", 32'(done), 32'd0);
      check_eq("midrst_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Four scans with Ghost1 on Pac: exercises the invulnerability window.
    for (int s = 0; s < 4; s++) begin
      px = 400; py = 250; set_far(); gx[0] = 400; gy[0] = 250;
      do_scan("overlap", 0);
    end

    // Tick during the REPORT cycle is an overrun, not a new scan.
    px = 50; py = 60; set_far();
    do_scan("ovr_report", 7);

    for (int n = 0; n < 40; n++) begin
      px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 511));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          gx[i] = int'($urandom_range(0, 1023)); gy[i] = int'($urandom_range(0, 511));
        end else begin
          gx[i] = clampi(px + int'($urandom_range(0, 80)) - 40, 1023);
          gy[i] = clampi(py + int'($urandom_range(0, 80)) - 40, 511);
        end
      end
      extra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      do_scan("rand", extra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
